// File: rtl/counter_share_arbiter_pkg.sv
// Shared types and helpers for the counter-sharing interval arbiter.
// Round-robin pick is sized for the largest supported requester count.
package counter_share_pkg;

    localparam int MAX_N    = 16;
    localparam int IDXW_MAX = $clog2(MAX_N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // First set bit at or above ptr, wrapping at n-1 back to 0.
    function automatic logic [IDXW_MAX-1:0] rr_pick(
        input logic [MAX_N-1:0]    req,
        input logic [IDXW_MAX-1:0] ptr,
        input int                  n
    );
        logic [IDXW_MAX-1:0] pick;
        logic                found;
        int                  idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_N; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && req[idx]) begin
                pick  = IDXW_MAX'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/counter_share_arbiter_share_counter.sv
// W-bit up-counter with synchronous clear and enable; clear wins over enable.
module share_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/counter_share_arbiter.sv
// Round-robin arbiter that lends one shared up-counter to N requesters as an interval timer.
// The winner's terminal count is latched at grant; done pulses for one cycle when it is reached.
module counter_share_arbiter
    import counter_share_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] limit_flat,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic           busy,
    output logic [W-1:0]   count
);

    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] owner;
    logic [IDXW-1:0] winner;
    logic [IDXW-1:0] next_ptr;
    logic [W-1:0]    lim_q;
    logic            abort;
    logic            at_limit;
    logic            clr;
    logic            en;

    assign winner   = IDXW'(rr_pick(MAX_N'(req), IDXW_MAX'(ptr), N));
    assign next_ptr = (owner == IDXW'(N - 1)) ? '0 : owner + 1'b1;
    assign abort    = (state == RUN) && !req[owner];
    assign at_limit = (count == lim_q);

    // Counter sits at zero outside RUN; it also clears on the cycle an abort is seen.
    assign clr = (state != RUN) || abort;
    assign en  = (state == RUN) && !at_limit;

    share_counter #(.W(W)) u_counter (
        .clock (clock),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .count (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            owner <= '0;
            lim_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (|req) begin
                        state         <= RUN;
                        owner         <= winner;
                        grant         <= '0;
                        grant[winner] <= 1'b1;
                        lim_q         <= limit_flat[winner*W +: W];
                        busy          <= 1'b1;
                    end
                end
                RUN: begin
                    // A dropped request aborts the interval even on the terminal cycle.
                    if (abort) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= next_ptr;
                    end else if (at_limit) begin
                        state <= DONE;
                        done  <= grant;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                    ptr   <= next_ptr;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Directed bench for counter_share_arbiter with a done-event scoreboard.
module tb_counter_share_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] limit_flat;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  count;

    typedef struct {
        logic [3:0] done_vec;
        logic [3:0] count_val;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    counter_share_arbiter #(.N(4), .W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .limit_flat (limit_flat),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .count      (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [15:0] l);
        req        = r;
        limit_flat = l;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic expectDone(input logic [3:0] d, input logic [3:0] c);
        exp_t e;
        e.done_vec  = d;
        e.count_val = c;
        sbq.push_back(e);
    endtask

    // Every done pulse must match the next queued interval completion.
    always @(negedge clock) begin
        if (!reset && done != 4'b0000) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got %b expected none", done);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("sb_done", 32'(done), 32'(e.done_vec));
                checkOutput("sb_count", 32'(count), 32'(e.count_val));
                checkOutput("sb_grant", 32'(grant), 32'(e.done_vec));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [3:0] rot [5];

    initial begin
        rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100;
        rot[3] = 4'b1000; rot[4] = 4'b0001;
        reset = 1'b1;
        applyStimulus(4'b0000, 16'h0000);
        tick;
        tick;
        checkOutput("rst_grant", 32'(grant), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_count", 32'(count), 0);
        reset = 1'b0;

        // Single requester, limit 3
        applyStimulus(4'b0001, 16'h0003);
        expectDone(4'b0001, 4'd3);
        tick;
        checkOutput("t1_grant", 32'(grant), 32'h1);
        checkOutput("t1_busy", 32'(busy), 1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t1_count", 32'(count), 32'(k));
            checkOutput("t1_nodone", 32'(done), 0);
            tick;
        end
        checkOutput("t1_done", 32'(done), 32'h1);
        checkOutput("t1_hold", 32'(count), 3);
        applyStimulus(4'b0000, 16'h0003);
        tick;
        checkOutput("t1_release", 32'(grant), 0);
        checkOutput("t1_count0", 32'(count), 0);
        checkOutput("t1_idle", 32'(busy), 0);

        // Pointer now 1: requester 2 beats requester 0
        applyStimulus(4'b0101, 16'h0100);
        expectDone(4'b0100, 4'd1);
        expectDone(4'b0001, 4'd0);
        tick;
        checkOutput("t3_grant2", 32'(grant), 32'h4);
        tick;
        checkOutput("t3_count", 32'(count), 1);
        tick;
        checkOutput("t3_done2", 32'(done), 32'h4);
        applyStimulus(4'b0001, 16'h0100);
        tick;
        checkOutput("t3_gap", 32'(grant), 0);
        tick;
        checkOutput("t3_grant0", 32'(grant), 32'h1);
        tick;
        checkOutput("t3_done0", 32'(done), 32'h1);
        applyStimulus(4'b0000, 16'h0000);
        tick;

        // Rotation with all requesters and zero limits
        reset = 1'b1;
        tick;
        reset = 1'b0;
        applyStimulus(4'b1111, 16'h0000);
        for (int i = 0; i < 5; i++) expectDone(rot[i], 4'd0);
        for (int i = 0; i < 5; i++) begin
            tick;
            checkOutput("t2_grant", 32'(grant), 32'(rot[i]));
            tick;
            checkOutput("t2_done", 32'(done), 32'(rot[i]));
            if (i == 4) applyStimulus(4'b0000, 16'h0000);
            tick;
            checkOutput("t2_gap", 32'(grant), 0);
        end

        // Abort: requester 0 drops at count 1, pointer then 1
        applyStimulus(4'b0001, 16'h0002);
        tick;
        checkOutput("t4_grant", 32'(grant), 32'h1);
        tick;
        checkOutput("t4_count", 32'(count), 1);
        applyStimulus(4'b0000, 16'h0002);
        tick;
        checkOutput("t4_grant0", 32'(grant), 0);
        checkOutput("t4_count0", 32'(count), 0);
        checkOutput("t4_nodone", 32'(done), 0);
        checkOutput("t4_busy", 32'(busy), 0);
        applyStimulus(4'b0011, 16'h0000);
        expectDone(4'b0010, 4'd0);
        tick;
        checkOutput("t4_ptr", 32'(grant), 32'h2);
        tick;
        checkOutput("t4_done1", 32'(done), 32'h2);
        applyStimulus(4'b0000, 16'h0000);
        tick;

        // Reset mid-run at count 5 (pointer was 2)
        applyStimulus(4'b0100, 16'h0900);
        tick;
        checkOutput("t6_grant", 32'(grant), 32'h4);
        for (int k = 0; k < 5; k++) tick;
        checkOutput("t6_count5", 32'(count), 5);
        reset = 1'b1;
        tick;
        checkOutput("t6_grant0", 32'(grant), 0);
        checkOutput("t6_done0", 32'(done), 0);
        checkOutput("t6_busy0", 32'(busy), 0);
        checkOutput("t6_count0", 32'(count), 0);
        reset = 1'b0;
        applyStimulus(4'b1001, 16'h0000);
        expectDone(4'b0001, 4'd0);
        tick;
        checkOutput("t6_ptr0", 32'(grant), 32'h1);
        tick;
        applyStimulus(4'b0000, 16'h0000);
        tick;

        // Full-range limit, mid-run limit change ignored (pointer 1 -> winner 3)
        applyStimulus(4'b1000, 16'hF000);
        expectDone(4'b1000, 4'd15);
        tick;
        checkOutput("t5_grant", 32'(grant), 32'h8);
        checkOutput("t5_count0", 32'(count), 0);
        applyStimulus(4'b1000, 16'h2000);
        for (int k = 1; k < 16; k++) begin
            tick;
            checkOutput("t5_count", 32'(count), 32'(k));
        end
        tick;
        checkOutput("t5_done", 32'(done), 32'h8);
        checkOutput("t5_nowrap", 32'(count), 15);
        applyStimulus(4'b0000, 16'h0000);
        tick;
        checkOutput("t5_release", 32'(grant), 0);
        tick;
        tick;
        checkOutput("sb_empty", 32'(sbq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
